// File: rtl/johnson_seq_ctrl_pkg.sv
// Shared types and helpers for the Johnson ring sequencer.
// The jc_legal/jc_index helpers take the ring zero-extended to 16 bits plus the live width.
package johnson_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

   // Ones count over the first w bits of q.
   function automatic int unsigned jc_popcount(logic [15:0] q, int unsigned w);
      int unsigned k;
      k = 0;
      for (int i = 0; i < 16; i++) begin
         if (i < int'(w) && q[i]) k++;
      end
      return k;
   endfunction

   // Ones packed against the MSB end of a w-bit field (covers 0 and all-ones).
   function automatic logic [31:0] jc_msb_pat(int unsigned w, int unsigned k);
      logic [31:0] mask;
      mask = (32'd1 << w) - 32'd1;
      return mask & ~((32'd1 << (w - k)) - 32'd1);
   endfunction

   function automatic logic jc_legal(logic [15:0] q, int unsigned w);
      int unsigned k;
      logic [31:0] qx;
      k  = jc_popcount(q, w);
      qx = {16'h0000, q};
      return (qx == jc_msb_pat(w, k)) || (qx == ((32'd1 << k) - 32'd1));
   endfunction

   // MSB-aligned ones map to k, LSB-aligned to 2w-k; illegal codes map to 0.
   function automatic int unsigned jc_index(logic [15:0] q, int unsigned w);
      int unsigned k;
      logic [31:0] qx;
      k  = jc_popcount(q, w);
      qx = {16'h0000, q};
      if (qx == jc_msb_pat(w, k)) return k;
      if (qx == ((32'd1 << k) - 32'd1)) return 2 * w - k;
      return 0;
   endfunction

endpackage

// File: rtl/johnson_seq_ctrl_if.sv
// Host-side command/status bundle for the Johnson ring sequencer.
interface johnson_seq_ctrl_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8,
   parameter int unsigned IDX_W = $clog2(2 * WIDTH)
);
   logic             start;
   logic [CNT_W-1:0] steps;
   logic             dir;
   logic             abort;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] q;
   logic [2*WIDTH-1:0] phase;
   logic [IDX_W-1:0] phase_idx;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, steps, dir, abort, load, load_val,
      input  q, phase, phase_idx, busy, done, err
   );

   modport slave (
      input  start, steps, dir, abort, load, load_val,
      output q, phase, phase_idx, busy, done, err
   );
endinterface

// File: rtl/johnson_ring_core.sv
// Johnson ring register (clear > load > step) and its phase decode.
module johnson_ring_core
   import johnson_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned IDX_W = $clog2(2 * WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_en,
   input  logic               i_dir,
   input  logic               i_load,
   input  logic [WIDTH-1:0]   i_load_val,
   input  logic               i_clear,
   output logic [WIDTH-1:0]   o_q,
   output logic [2*WIDTH-1:0] o_phase,
   output logic [IDX_W-1:0]   o_phase_idx,
   output logic               o_legal
);
   logic [WIDTH-1:0] r_q;
   logic [15:0]      w_q16;
   int unsigned      w_idx;

   // Ring register update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= '0;
      end else if (i_clear) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_load_val;
      end else if (i_en) begin
         if (i_dir == DIR_REV) r_q <= {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
         else                  r_q <= {~r_q[0], r_q[WIDTH-1:1]};
      end
   end

   // Combinational decode of the ring into one-hot phase and index.
   always_comb begin
      w_q16       = 16'(r_q);
      o_legal     = jc_legal(w_q16, WIDTH);
      w_idx       = jc_index(w_q16, WIDTH);
      o_phase_idx = IDX_W'(w_idx);
      o_phase     = o_legal ? ((2*WIDTH)'(1) << w_idx) : '0;
   end

   assign o_q = r_q;
endmodule

// File: rtl/johnson_seq_ctrl.sv
// Johnson ring sequencer: runs the ring N steps either way, then pulses done.
// Define JOHNSON_SELF_CORRECT_EN to clear illegal ring codes and pulse err.
module johnson_seq_ctrl
   import johnson_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input logic               clk,
   input logic               reset,
   johnson_seq_ctrl_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(2 * WIDTH);

   state_e           r_state, w_state_d;
   logic [CNT_W-1:0] r_rem, w_rem_d;
   logic             r_dir, w_dir_d;
   logic             r_err, w_err_d;
   logic             w_en, w_load, w_clear, w_legal, w_fix;
   logic [WIDTH-1:0] w_q;
   logic [2*WIDTH-1:0] w_phase;
   logic [IDX_W-1:0] w_phase_idx;

   johnson_ring_core #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_core (
      .clk         (clk),
      .reset       (reset),
      .i_en        (w_en),
      .i_dir       (r_dir),
      .i_load      (w_load),
      .i_load_val  (bus.load_val),
      .i_clear     (w_clear),
      .o_q         (w_q),
      .o_phase     (w_phase),
      .o_phase_idx (w_phase_idx),
      .o_legal     (w_legal)
   );

`ifdef JOHNSON_SELF_CORRECT_EN
   assign w_fix = ~w_legal;
`else
   assign w_fix = 1'b0;
`endif

   // Controller state, remaining-step count, latched direction, err pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= StIdle;
         r_rem   <= '0;
         r_dir   <= DIR_FWD;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_rem   <= w_rem_d;
         r_dir   <= w_dir_d;
         r_err   <= w_err_d;
      end
   end

   // Next-state and ring controls; correction outranks every command.
   always_comb begin
      w_state_d = r_state;
      w_rem_d   = r_rem;
      w_dir_d   = r_dir;
      w_err_d   = 1'b0;
      w_en      = 1'b0;
      w_load    = 1'b0;
      w_clear   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_fix) begin
               w_clear = 1'b1;
               w_err_d = 1'b1;
            end else if (bus.abort) begin
               w_state_d = StIdle;
            end else if (bus.load) begin
               w_load = 1'b1;
            end else if (bus.start) begin
               if (bus.steps == '0) begin
                  w_state_d = StDone;
               end else begin
                  w_rem_d   = bus.steps;
                  w_dir_d   = bus.dir;
                  w_state_d = StRun;
               end
            end
         end
         StRun: begin
            if (w_fix) begin
               w_clear   = 1'b1;
               w_err_d   = 1'b1;
               w_state_d = StIdle;
            end else if (bus.abort) begin
               w_state_d = StIdle;
            end else begin
               w_en    = 1'b1;
               w_rem_d = r_rem - CNT_W'(1);
               if (r_rem == CNT_W'(1)) w_state_d = StDone;
            end
         end
         StDone: w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   assign bus.q         = w_q;
   assign bus.phase     = w_phase;
   assign bus.phase_idx = w_phase_idx;
   assign bus.busy      = (r_state == StRun);
   assign bus.done      = (r_state == StDone);
   assign bus.err       = r_err;
endmodule
